// File: rtl/rsa_pkg.sv
// Shared width, FSM state and Montgomery op encodings for the RSA exponentiation sequencer.
package rsa_pkg;

    localparam int unsigned WIDTH = 256;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        OpPreY,
        OpPreAcc,
        OpSqr,
        OpMul,
        OpPost
    } op_e;

endpackage

// File: rtl/mm_operand_sel.sv
// Picks the Montgomery multiplier (a, b) operand pair for the current schedule op.
module mm_operand_sel
    import rsa_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) (
    input  op_e              op_i,
    input  logic [Width-1:0] acc_i,
    input  logic [Width-1:0] ym_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] r2_i,
    output logic [Width-1:0] a_o,
    output logic [Width-1:0] b_o
);

    localparam logic [Width-1:0] One = Width'(1);

    always_comb begin
        a_o = '0;
        b_o = '0;
        case (op_i)
            OpPreY: begin
                a_o = y_i;
                b_o = r2_i;
            end
            OpPreAcc: begin
                a_o = One;
                b_o = r2_i;
            end
            OpSqr: begin
                a_o = acc_i;
                b_o = acc_i;
            end
            OpMul: begin
                a_o = acc_i;
                b_o = ym_i;
            end
            OpPost: begin
                a_o = acc_i;
                b_o = One;
            end
            default: begin
                a_o = '0;
                b_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing Y^E mod N on one Montgomery multiplier.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [Width-1:0] y,
    input  logic [Width-1:0] e,
    input  logic [Width-1:0] n,
    input  logic [Width-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] result,
    output logic [Width-1:0] mont_a,
    output logic [Width-1:0] mont_b,
    output logic [Width-1:0] mont_n,
    output logic             mont_beg,
    input  logic [Width-1:0] mont_out,
    input  logic             mont_out_ready
);

    localparam int unsigned IdxW = $clog2(Width);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [Width-1:0] y_q, y_d, e_q, e_d, n_q, n_d, r2_q, r2_d;
    logic [Width-1:0] ym_q, ym_d, acc_q, acc_d, result_q, result_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d, sel_a, sel_b;
    logic             busy_q, busy_d, done_q, done_d, beg_q, beg_d;

    // Fed from next-state values so the registered operands are valid throughout LOAD.
    mm_operand_sel #(
        .Width(Width)
    ) u_sel (
        .op_i (op_d),
        .acc_i(acc_d),
        .ym_i (ym_d),
        .y_i  (y_d),
        .r2_i (r2_d),
        .a_o  (sel_a),
        .b_o  (sel_b)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        y_d      = y_q;
        e_d      = e_q;
        n_d      = n_q;
        r2_d     = r2_q;
        ym_d     = ym_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    y_d     = y;
                    e_d     = e;
                    n_d     = n;
                    r2_d    = r2;
                    op_d    = OpPreY;
                    idx_d   = IdxW'(Width - 1);
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                if (!mont_out_ready) begin
                    state_d = StLoad;
                    case (op_q)
                        OpPreY: begin
                            ym_d = mont_out;
                            op_d = OpPreAcc;
                        end
                        OpPreAcc: begin
                            acc_d = mont_out;
                            op_d  = OpSqr;
                        end
                        OpSqr: begin
                            acc_d = mont_out;
                            if (e_q[idx_q]) begin
                                op_d = OpMul;
                            end else if (idx_q == '0) begin
                                op_d = OpPost;
                            end else begin
                                idx_d = idx_q - 1'b1;
                            end
                        end
                        OpMul: begin
                            acc_d = mont_out;
                            if (idx_q == '0) begin
                                op_d = OpPost;
                            end else begin
                                op_d  = OpSqr;
                                idx_d = idx_q - 1'b1;
                            end
                        end
                        OpPost: begin
                            result_d = mont_out;
                            state_d  = StDone;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        a_d    = (state_d == StLoad) ? sel_a : a_q;
        b_d    = (state_d == StLoad) ? sel_b : b_q;
        busy_d = (state_d == StLoad) || (state_d == StRun);
        done_d = (state_d == StDone);
        beg_d  = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OpPreY;
            idx_q    <= '0;
            y_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            ym_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            beg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            y_q      <= y_d;
            e_q      <= e_d;
            n_q      <= n_d;
            r2_q     <= r2_d;
            ym_q     <= ym_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            beg_q    <= beg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mont_a   = a_q;
    assign mont_b   = b_q;
    assign mont_n   = n_q;
    assign mont_beg = beg_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Directed bench for rsa_exp_ctrl at a reduced width with a cycle-accurate multiplier stand-in.
module tb_rsa_exp_ctrl;

    // W=16 keeps 2^W mod 13 = 3 (as for 256), so r2=9 and R^-1=9 are unchanged.
    localparam int unsigned W      = 16;
    localparam int unsigned LAT    = W + 3;
    localparam int unsigned OP_CYC = W + 4;
    localparam int unsigned NMOD   = 13;
    localparam int unsigned RINV   = 9;
    localparam int          LIMIT  = OP_CYC * (2 * W + 3) + 20;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] y = '0, e = '0, n = W'(NMOD), r2 = W'(9);
    logic         busy, done, mont_beg, mont_out_ready;
    logic [W-1:0] result, mont_a, mont_b, mont_n, mont_out;

    int n_checks = 0;
    int n_pass = 0;
    int done_cyc, ops, gap_bad, overlap;

    always #5 clk = ~clk;

    rsa_exp_ctrl #(
        .Width(W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .y             (y),
        .e             (e),
        .n             (n),
        .r2            (r2),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .mont_a        (mont_a),
        .mont_b        (mont_b),
        .mont_n        (mont_n),
        .mont_beg      (mont_beg),
        .mont_out      (mont_out),
        .mont_out_ready(mont_out_ready)
    );

    // Multiplier stand-in: loads while beg is low, ready drops in RUN cycle LAT and stays low.
    function automatic logic [W-1:0] mont_f(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ar, br;
        ar = int'(a % W'(NMOD));
        br = int'(b % W'(NMOD));
        return W'((ar * br * RINV) % NMOD);
    endfunction

    logic [W-1:0] mm_q;
    int unsigned  mm_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_cnt <= 0;
            mm_q   <= '0;
        end else if (!mont_beg) begin
            mm_cnt <= 0;
            mm_q   <= mont_f(mont_a, mont_b);
        end else if (mm_cnt != LAT - 1) begin
            mm_cnt <= mm_cnt + 1;
        end
    end

    assign mont_out       = mm_q;
    assign mont_out_ready = (mm_cnt != LAT - 1);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Cycle k is the k-th cycle after the edge that accepts start; sampled at its negedge.
    task automatic run_exp(input logic [W-1:0] yv, input logic [W-1:0] ev, input int rp1,
                           input int rp2, input int abort_at);
        int   gap;
        logic prev_beg;
        done_cyc = 0;
        ops      = 0;
        gap_bad  = 0;
        overlap  = 0;
        gap      = 0;
        prev_beg = 1'b0;
        @(negedge clk);
        y     = yv;
        e     = ev;
        start = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            y     = '0;
            e     = '0;
            start = (k == rp1) || (k == rp2);
            if (k == abort_at) begin
                reset_n = 1'b0;
                break;
            end
            if (busy && done) overlap++;
            if (mont_beg && !prev_beg) begin
                ops++;
                if (gap != 1) gap_bad++;
            end
            if (!mont_beg && busy) gap++;
            else if (mont_beg) gap = 0;
            prev_beg = mont_beg;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int pop, input logic [W-1:0] exp_res);
        check({tag, "_done_cycle"}, done_cyc, OP_CYC * (W + 3 + pop) + 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_ops"}, ops, W + 3 + pop);
        check({tag, "_beg_gap"}, gap_bad, 0);
        check({tag, "_busy_done"}, overlap, 0);
    endtask

    task automatic check_hold(input string tag, input logic [W-1:0] exp_res);
        int changed;
        changed = 0;
        repeat (8) begin
            @(negedge clk);
            if (result !== exp_res || busy !== 1'b0) changed++;
        end
        check({tag, "_hold"}, changed, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_beg", mont_beg, 0);
        check("rst_operands", mont_a | mont_b | mont_n, 0);
        reset_n = 1'b1;

        // y=2, e=5: 2^5 = 32 = 6 mod 13
        run_exp(W'(2), W'(5), 0, 0, 0);
        check_run("e5", 2, W'(6));
        check("e5_mont_n", mont_n, NMOD);
        // start coincident with done must be ignored
        y     = W'(7);
        e     = W'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_hold("e5", W'(6));

        run_exp(W'(2), W'(0), 0, 0, 0);
        check_run("e0", 0, W'(1));
        check_hold("e0", W'(1));

        // 3 has order 3 mod 13 and 2^16-1 is divisible by 3
        run_exp(W'(3), '1, 0, 0, 0);
        check_run("eones", W, W'(1));

        run_exp(W'(2), W'(5), 10, OP_CYC * 15, 0);
        check_run("repulse", 2, W'(6));

        run_exp(W'(2), W'(5), 0, 0, 100);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_beg", mont_beg, 0);
        check("abort_result", result, 0);
        check("abort_operands", mont_a | mont_b | mont_n, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // y=4, e=3: 64 = 12 mod 13
        run_exp(W'(4), W'(3), 0, 0, 0);
        check_run("post_rst", 2, W'(12));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
